// File: rtl/moving_average_param.sv
// Sliding-window moving average over a runtime-selectable power-of-two window.
// Strobe-edge sample input, round-half-up output, fill status and sticky overrun.
module moving_average_param #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned LOG2_MAX_N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              strobe_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [2:0]        win_log2,
  output logic [DATA_W-1:0] data_out,
  output logic              strobe_out,
  output logic              window_full,
  output logic              overrun
);

  localparam int unsigned MAX_N = 1 << LOG2_MAX_N;
  localparam int unsigned SUM_W = DATA_W + LOG2_MAX_N;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_UPDATE} state_t;

  state_t                  r_state, w_state_next;
  logic [DATA_W-1:0]       r_buf [MAX_N];
  logic [LOG2_MAX_N-1:0]   r_wr_ptr;
  logic [SUM_W-1:0]        r_sum;
  logic [LOG2_MAX_N:0]     r_fill;
  logic [2:0]              r_k_act;
  logic [DATA_W-1:0]       r_in;
  logic                    r_strobe_d;
  logic [DATA_W-1:0]       r_data_out;
  logic                    r_strobe_out;
  logic                    r_window_full;
  logic                    r_overrun;

  logic [2:0]              w_k_req;
  logic                    w_event;
  logic                    w_flush;
  logic [LOG2_MAX_N:0]     w_span;
  logic [LOG2_MAX_N-1:0]   w_rd_ptr;
  logic [DATA_W-1:0]       w_oldest;
  logic [SUM_W-1:0]        w_sum_next;
  logic [LOG2_MAX_N:0]     w_fill_inc;
  logic [SUM_W-1:0]        w_round;
  logic [SUM_W-1:0]        w_rounded;
  logic [DATA_W-1:0]       w_avg;

  assign w_k_req  = (win_log2 > 3'(LOG2_MAX_N)) ? 3'(LOG2_MAX_N) : win_log2;
  assign w_event  = ena & strobe_in & ~r_strobe_d;
  assign w_flush  = (r_state == S_IDLE) && (w_k_req != r_k_act);

  // Window of MAX_N wraps the span to 0, so the oldest slot is the one about to be overwritten.
  assign w_span     = {{LOG2_MAX_N{1'b0}}, 1'b1} << r_k_act;
  assign w_rd_ptr   = r_wr_ptr - w_span[LOG2_MAX_N-1:0];
  assign w_oldest   = r_buf[w_rd_ptr];
  assign w_sum_next = r_sum + SUM_W'(r_in) - SUM_W'(w_oldest);
  assign w_fill_inc = (r_fill == w_span) ? r_fill : r_fill + (LOG2_MAX_N+1)'(1);
  assign w_round    = (r_k_act == 3'd0) ? '0 : SUM_W'(w_span >> 1);
  assign w_rounded  = r_sum + w_round;
  assign w_avg      = DATA_W'(w_rounded >> r_k_act);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_event) w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_UPDATE;
      S_UPDATE:  w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_N; i++) r_buf[i] <= '0;
      r_wr_ptr      <= '0;
      r_sum         <= '0;
      r_fill        <= '0;
      r_k_act       <= '0;
      r_in          <= '0;
      r_strobe_d    <= 1'b0;
      r_data_out    <= '0;
      r_strobe_out  <= 1'b0;
      r_window_full <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_strobe_d   <= strobe_in;
      r_strobe_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Flush and capture may coincide: the captured sample opens the new window.
          if (w_flush) begin
            for (int unsigned i = 0; i < MAX_N; i++) r_buf[i] <= '0;
            r_wr_ptr      <= '0;
            r_sum         <= '0;
            r_fill        <= '0;
            r_window_full <= 1'b0;
            r_overrun     <= 1'b0;
            r_k_act       <= w_k_req;
          end
          if (w_event) r_in <= data_in;
        end
        S_CAPTURE: begin
          r_sum           <= w_sum_next;
          r_buf[r_wr_ptr] <= r_in;
          r_wr_ptr        <= r_wr_ptr + LOG2_MAX_N'(1);
          r_fill          <= w_fill_inc;
          r_window_full   <= (w_fill_inc == w_span);
          if (w_event) r_overrun <= 1'b1;
        end
        S_UPDATE: begin
          r_data_out   <= w_avg;
          r_strobe_out <= 1'b1;
          if (w_event) r_overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign data_out    = r_data_out;
  assign strobe_out  = r_strobe_out;
  assign window_full = r_window_full;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_moving_average_param.sv
// Directed and randomized bench for moving_average_param against a sample-history model.
module tb_moving_average_param;

  localparam int DW = 10;
  localparam int LG = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          strobe_in;
  logic [DW-1:0] data_in;
  logic [2:0]    win_log2;
  logic [DW-1:0] data_out;
  logic          strobe_out;
  logic          window_full;
  logic          overrun;

  int checks   = 0;
  int failures = 0;

  int hist[$];
  int km;
  bit ovm;
  int last_out;

  always #5 clk = ~clk;

  moving_average_param #(.DATA_W(DW), .LOG2_MAX_N(LG)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .strobe_in(strobe_in),
    .data_in(data_in), .win_log2(win_log2), .data_out(data_out),
    .strobe_out(strobe_out), .window_full(window_full), .overrun(overrun)
  );

  function automatic int clampk(input int w);
    return (w > LG) ? LG : w;
  endfunction

  function automatic int exp_avg();
    int     n;
    longint s;
    n = 1 << km;
    s = 0;
    for (int i = 0; i < n && i < hist.size(); i++) s += hist[hist.size()-1-i];
    return int'((s + ((km != 0) ? n/2 : 0)) >> km);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_flush_if(input int w);
    if (clampk(w) != km) begin
      km = clampk(w);
      hist.delete();
      ovm = 1'b0;
    end
  endtask

  // One full sample transaction with exact-latency checks.
  task automatic send(input int d, input int w);
    @(posedge clk); #1;
    strobe_in = 1'b1; data_in = DW'(d); win_log2 = 3'(w);
    model_flush_if(w);
    @(posedge clk); #1;
    strobe_in = 1'b0;
    hist.push_back(d);
    if (hist.size() > (1 << LG)) void'(hist.pop_front());
    chk("strobe_early", 32'(strobe_out), 0);
    @(posedge clk); #1;
    chk("window_full", 32'(window_full), 32'(hist.size() >= (1 << km)));
    chk("overrun", 32'(overrun), 32'(ovm));
    @(posedge clk); #1;
    last_out = exp_avg();
    chk("strobe_out", 32'(strobe_out), 1);
    chk("data_out", 32'(data_out), 32'(last_out));
    @(posedge clk); #1;
    chk("strobe_one_cycle", 32'(strobe_out), 0);
  endtask

  initial begin
    int cnt;
    int w;
    rst_n = 1'b0; ena = 1'b1; strobe_in = 1'b0; data_in = '0; win_log2 = 3'd2;
    hist.delete(); km = 2; ovm = 1'b0; last_out = 0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_strobe_out", 32'(strobe_out), 0);
    chk("rst_window_full", 32'(window_full), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (strobe_out) cnt++;
    end
    chk("idle_no_strobe", 32'(cnt), 0);

    // k=2 ramp 25,50,75,100 with 25-cycle spacing
    for (int i = 0; i < 4; i++) begin
      send(100, 2);
      repeat (20) @(posedge clk);
    end
    chk("ramp_final", 32'(data_out), 100);
    chk("ramp_full", 32'(window_full), 1);

    // Rounding with k=1
    send(1, 1);
    chk("round_1", 32'(data_out), 1);
    send(2, 1);
    chk("round_2", 32'(data_out), 2);

    // Full scale with k=3
    for (int i = 0; i < 8; i++) send(1023, 3);
    chk("full_scale", 32'(data_out), 1023);
    send(0, 3);
    chk("full_scale_drop", 32'(data_out), 895);

    // Window change with simultaneous sample
    for (int i = 0; i < 4; i++) send(400, 2);
    chk("steady_400", 32'(data_out), 400);
    send(200, 1);
    chk("flush_first", 32'(data_out), 100);
    send(200, 1);
    chk("flush_second", 32'(data_out), 200);

    // Over-range exponent clamps to the maximum window
    for (int i = 0; i < 9; i++) send(8 * i + 3, 5);
    send(777, 0);
    chk("bypass", 32'(data_out), 777);

    // Overrun: second edge two cycles after the first
    @(posedge clk); #1;
    strobe_in = 1'b1; data_in = DW'(500);
    @(posedge clk); #1;
    strobe_in = 1'b0;
    hist.push_back(500);
    @(posedge clk); #1;
    strobe_in = 1'b1; data_in = DW'(9);
    @(posedge clk); #1;
    strobe_in = 1'b0;
    ovm = 1'b1;
    chk("ovr_strobe", 32'(strobe_out), 1);
    chk("ovr_data", 32'(data_out), 500);
    chk("ovr_flag", 32'(overrun), 1);
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (strobe_out) cnt++;
    end
    chk("ovr_single_strobe", 32'(cnt), 0);
    send(300, 0);
    chk("ovr_sticky", 32'(overrun), 1);
    send(40, 2);
    chk("ovr_cleared", 32'(overrun), 0);

    // ena low: edge ignored, state held
    ena = 1'b0;
    @(posedge clk); #1;
    strobe_in = 1'b1; data_in = DW'(1000);
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (strobe_out) cnt++;
    end
    strobe_in = 1'b0;
    @(posedge clk); #1;
    ena = 1'b1;
    chk("ena_low_ignored", 32'(cnt), 0);
    send(60, 2);

    // Randomized samples with occasional window changes
    w = 2;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) w = $urandom_range(0, 7);
      send($urandom_range(0, (1 << DW) - 1), w);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // Reset asserted mid-pipeline aborts the sample
    @(posedge clk); #1;
    strobe_in = 1'b1; data_in = DW'(123);
    @(posedge clk); #1;
    strobe_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_data_out", 32'(data_out), 0);
    chk("midrst_window_full", 32'(window_full), 0);
    chk("midrst_overrun", 32'(overrun), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hist.delete(); ovm = 1'b0; km = clampk(int'(win_log2));
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (strobe_out) cnt++;
    end
    chk("midrst_no_strobe", 32'(cnt), 0);
    send(321, 1);
    send(654, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
